// File: rtl/cache_pkg.sv
// Shared definitions for the L2 cache / main memory slice: responder FSM
// encodings, word sizing and block offset derivation.
package cache_pkg;

    // Main memory responder states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } mem_state_t;

    // Bytes per word for the default 32-bit data path.
    localparam int BYTES_PER_WORD = 4;

    // Bytes per word for an arbitrary (multiple-of-8) data width.
    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // Number of byte-offset bits inside a cache block; the L2 cache uses the
    // same derivation to split tag/index/offset.
    function automatic int offset_width(input int block_size);
        return $clog2(block_size);
    endfunction

endpackage

// File: rtl/main_memory_if.sv
// Cache <-> main memory request/response bus.
//
// Handshake: the master holds mem_read and/or mem_write high (a level, not a
// pulse) together with a stable mem_addr/mem_data_out until the slave raises
// mem_ready for exactly one cycle; mem_data_in is meaningful only in that
// cycle. Dropping both request levels before mem_ready abandons the request.
// mem_write wins when both request levels are high.
interface main_memory_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;

    // Cache side.
    modport master (
        output mem_addr,
        output mem_data_out,
        output mem_read,
        output mem_write,
        input  mem_data_in,
        input  mem_ready
    );

    // Memory side.
    modport slave (
        input  mem_addr,
        input  mem_data_out,
        input  mem_read,
        input  mem_write,
        output mem_data_in,
        output mem_ready
    );
endinterface

// File: rtl/mem_word_array.sv
// Word storage for the main memory model: synchronous write port,
// asynchronous read port. Contents are deliberately not reset.
module mem_word_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: one word per enabled rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/main_memory.sv
// Main memory responder for the L2 cache: single-word read/write requests,
// configurable access latency, and an "open block" fast path for sequential
// beats inside one cache block.
module main_memory
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_DEPTH     = 4096,
    parameter int BLOCK_SIZE    = 32,
    parameter int FIRST_LATENCY = 4,
    parameter int BURST_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    main_memory_if.slave bus,
    output logic         busy,
    output mem_state_t   dbg_state
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int OFF_W = offset_width(BLOCK_SIZE);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = (FIRST_LATENCY > 1) ? $clog2(FIRST_LATENCY) : 1;

    mem_state_t              state;
    mem_state_t              next_state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_data;
    logic                    cap_write;
    logic                    open_q;
    logic [ADDR_WIDTH-1:0]   last_addr;

    logic                    req;
    logic                    seq_hit;
    logic [CNT_W-1:0]        load_val;
    logic                    arr_we;
    logic [DATA_WIDTH-1:0]   arr_rdata;
    logic [IDX_W-1:0]        cap_idx;

    assign req     = bus.mem_read | bus.mem_write;
    assign cap_idx = cap_addr[IDX_W+1:2];

    // A new request is a sequential beat only if the block is still open, it
    // is the very next word after the last completed one, and it stays inside
    // the same cache block.
    assign seq_hit = open_q
                  && (bus.mem_addr == last_addr + ADDR_WIDTH'(BPW))
                  && (bus.mem_addr[ADDR_WIDTH-1:OFF_W] == last_addr[ADDR_WIDTH-1:OFF_W]);

    // Counter holds L-1 so that reaching zero marks the last WAIT cycle.
    assign load_val = seq_hit ? CNT_W'(BURST_LATENCY - 1) : CNT_W'(FIRST_LATENCY - 1);

    assign dbg_state = state;

    mem_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (cap_idx),
        .wdata (cap_data),
        .raddr (cap_idx),
        .rdata (arr_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; an abort in WAIT takes priority over expiry.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    next_state = ST_IDLE;
                end else if (cnt == '0) begin
                    next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Output decode from the registered state; the array write fires on the
    // edge that enters RESPOND so a write is never partially committed.
    always_comb begin
        bus.mem_ready   = 1'b0;
        bus.mem_data_in = '0;
        busy            = 1'b0;
        arr_we          = 1'b0;
        case (state)
            ST_WAIT: begin
                busy   = 1'b1;
                arr_we = req && (cnt == '0) && cap_write;
            end
            ST_RESPOND: begin
                busy            = 1'b1;
                bus.mem_ready   = 1'b1;
                bus.mem_data_in = cap_write ? cap_data : arr_rdata;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Request capture, latency counter and open-block tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_write <= 1'b0;
            open_q    <= 1'b0;
            last_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cap_addr  <= bus.mem_addr;
                        cap_data  <= bus.mem_data_out;
                        cap_write <= bus.mem_write;
                        cnt       <= load_val;
                    end else begin
                        open_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        open_q <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESPOND: begin
                    open_q    <= 1'b1;
                    last_addr <= cap_addr;
                end
                default: begin
                    open_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
